pe_link_packer: RTL and testbench

Upstream feeder for the east input of a pass-through PE tile. Accepts a 32-bit valid/ready word stream from the local kernel, packs up to four words into one 164-bit link word with a header, and presents it registered on the tile's east link. It advances in lock-step with the downstream tile: it moves only while `ap_start` is high and holds its output otherwise.

---
 rtl/pe_link_pkg.sv | 32 +++
 rtl/pe_link_packer.sv | 109 ++++++++++
 tb/tb_pe_link_packer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pe_link_pkg.sv
// Shared field map and types for the PE east-link packer.
// The 164-bit link layout is fixed; the struct order matches the bit positions below.
package pe_link_pkg;

    localparam int unsigned LINK_WIDTH  = 164;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned LANES       = 4;
    localparam int unsigned LANE_W      = 2;
    localparam int unsigned SEQ_W       = 16;
    localparam int unsigned IDLE_W      = 8;

    localparam int unsigned VALID_BIT   = 163;
    localparam int unsigned LAST_BIT    = 162;
    localparam int unsigned CNT_LSB     = 160;
    localparam int unsigned SEQ_LSB     = 144;
    localparam int unsigned PAYLOAD_MSB = 127;

    typedef struct packed {
        logic                                valid;
        logic                                last;
        logic [LANE_W-1:0]                   cnt;
        logic [SEQ_W-1:0]                    seq;
        logic [15:0]                         rsvd;
        logic [LANES-1:0][DATA_WIDTH-1:0]    payload;
    } link_word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } pack_state_t;

endpackage

// File: rtl/pe_link_packer.sv
// Packs up to four 32-bit stream words into one registered 164-bit east-link word.
// Advances only while ap_start is high, in lock-step with the downstream tile.
module pe_link_packer
    import pe_link_pkg::*;
#(
    parameter int unsigned LINK_WIDTH   = pe_link_pkg::LINK_WIDTH,
    parameter int unsigned DATA_WIDTH   = pe_link_pkg::DATA_WIDTH,
    parameter int unsigned LANES        = pe_link_pkg::LANES,
    parameter int unsigned FLUSH_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ap_start,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [LINK_WIDTH-1:0] link_out
);

    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(FLUSH_CYCLES - 1);
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(LANES - 1);

    pack_state_t                      state_q, state_d;
    logic [LANE_W-1:0]                lane_q, lane_d;
    logic [IDLE_W-1:0]                idle_q, idle_d;
    logic [SEQ_W-1:0]                 seq_q, seq_d;
    logic [LANES-1:0][DATA_WIDTH-1:0] buf_q, buf_d;
    link_word_t                       link_q, link_d;

    logic                             accept;
    logic [LANES-1:0][DATA_WIDTH-1:0] buf_wr;

    assign s_ready  = ap_start & ~reset;
    assign accept   = s_valid & s_ready;
    assign link_out = link_q;

    always_comb begin
        buf_wr         = buf_q;
        buf_wr[lane_q] = s_data;
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        idle_d  = idle_q;
        seq_d   = seq_q;
        buf_d   = buf_q;
        link_d  = '0;

        if (!ap_start) begin
            link_d = link_q;
        end else if (accept) begin
            idle_d = '0;
            if (lane_q == LAST_LANE || s_last) begin
                link_d.valid   = 1'b1;
                link_d.last    = s_last;
                link_d.cnt     = lane_q;
                link_d.seq     = seq_q;
                link_d.payload = buf_wr;
                seq_d          = seq_q + 1'b1;
                buf_d          = '0;
                lane_d         = '0;
                state_d        = ST_IDLE;
            end else begin
                buf_d   = buf_wr;
                lane_d  = lane_q + 1'b1;
                state_d = ST_FILL;
            end
        end else if (state_q == ST_FILL) begin
            // An accept on the expiring cycle is handled above, so a flush never races a word.
            if (idle_q == IDLE_LIMIT) begin
                link_d.valid   = 1'b1;
                link_d.last    = 1'b0;
                link_d.cnt     = lane_q - 1'b1;
                link_d.seq     = seq_q;
                link_d.payload = buf_q;
                seq_d          = seq_q + 1'b1;
                buf_d          = '0;
                lane_d         = '0;
                idle_d         = '0;
                state_d        = ST_IDLE;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end else begin
            idle_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            idle_q  <= '0;
            seq_q   <= '0;
            buf_q   <= '0;
            link_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            idle_q  <= idle_d;
            seq_q   <= seq_d;
            buf_q   <= buf_d;
            link_q  <= link_d;
        end
    end

endmodule

// File: tb/tb_pe_link_packer.sv
// Scoreboard bench for pe_link_packer: stimulus pushes expected link words,
// a negedge monitor pops and compares on every active cycle.
module tb_pe_link_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic         ap_start;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [163:0] link_out;

    int           compared   = 0;
    int           mismatched = 0;
    logic [163:0] exp_q[$];
    logic [15:0]  exp_seq;
    logic         act_q = 1'b0;
    logic [163:0] held;

    always #5 clk = ~clk;

    pe_link_packer #(.FLUSH_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .ap_start (ap_start),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .link_out (link_out)
    );

    function automatic logic [163:0] mk(input logic last, input logic [1:0] cnt,
                                        input logic [15:0] seq, input logic [127:0] pl);
        return {1'b1, last, cnt, seq, 16'h0000, pl};
    endfunction

    // Active edge: the DUT register moved, so link_out must be a new word or a bubble.
    always @(posedge clk) act_q <= ap_start && !reset;

    always @(negedge clk) begin
        if (act_q) begin
            compared++;
            if (link_out[163]) begin
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_word: got %h, required no word", link_out);
                end else begin
                    logic [163:0] e;
                    e = exp_q.pop_front();
                    if (link_out !== e) begin
                        mismatched++;
                        $display("FAIL link_word: got %h, required %h", link_out, e);
                    end
                end
            end else if (link_out !== '0) begin
                mismatched++;
                $display("FAIL bubble: got %h, required 0", link_out);
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0);
    endtask

    task automatic check(input string name, input logic [163:0] got, input logic [163:0] req);
        compared++;
        if (got !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    initial begin
        reset    = 1'b1;
        ap_start = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        exp_seq  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_link", link_out, '0);
        check("reset_ready", {163'h0, s_ready}, '0);
        reset = 1'b0;
        #1;
        check("ready_active", {163'h0, s_ready}, 164'h1);

        // Full word, bubbles before it
        idle(2);
        drive(1'b1, 32'h11, 1'b0);
        drive(1'b1, 32'h22, 1'b0);
        drive(1'b1, 32'h33, 1'b0);
        exp_q.push_back(mk(1'b1, 2'd3, 16'd0, {32'h44, 32'h33, 32'h22, 32'h11}));
        drive(1'b1, 32'h44, 1'b1);

        // Partial last
        drive(1'b1, 32'hA, 1'b0);
        exp_q.push_back(mk(1'b1, 2'd1, 16'd1, {64'h0, 32'hB, 32'hA}));
        drive(1'b1, 32'hB, 1'b1);
        idle(1);

        // Flush after four idle active cycles
        exp_q.push_back(mk(1'b0, 2'd0, 16'd2, {96'h0, 32'h5}));
        drive(1'b1, 32'h5, 1'b0);
        idle(4);
        idle(1);

        // Accept on the expiring cycle wins; word lands in lane 1, then flushes
        drive(1'b1, 32'h5, 1'b0);
        idle(3);
        exp_q.push_back(mk(1'b0, 2'd1, 16'd3, {64'h0, 32'h6, 32'h5}));
        drive(1'b1, 32'h6, 1'b0);
        idle(4);
        idle(1);

        // Stall right after an emit
        held = mk(1'b1, 2'd0, 16'd4, {96'h0, 32'h99});
        exp_q.push_back(held);
        drive(1'b1, 32'h99, 1'b1);
        ap_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hDEAD, 1'b1);
            check("stall_hold", link_out, held);
            check("stall_ready", {163'h0, s_ready}, '0);
        end
        ap_start = 1'b1;
        exp_q.push_back(mk(1'b1, 2'd0, 16'd5, {96'h0, 32'h42}));
        drive(1'b1, 32'h42, 1'b1);
        idle(1);

        // Sequence wrap: 65536 single-word packets return seq to its start value
        exp_seq = 16'd6;
        for (int i = 0; i < 65536; i++) begin
            exp_q.push_back(mk(1'b1, 2'd0, exp_seq, {96'h0, 32'(i)}));
            exp_seq = exp_seq + 16'd1;
            drive(1'b1, 32'(i), 1'b1);
        end
        idle(1);

        // Reset mid-fill discards buffered words and restarts seq
        drive(1'b1, 32'h1, 1'b0);
        drive(1'b1, 32'h2, 1'b0);
        reset   = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("reset_midfill_link", link_out, '0);
        reset = 1'b0;
        exp_q.push_back(mk(1'b1, 2'd0, 16'd0, {96'h0, 32'h3}));
        drive(1'b1, 32'h3, 1'b1);
        idle(2);

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending words, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
